// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb control sequencer with memory-wait timeout.
// Optional perf counters (cycle_cnt, retired_cnt) are enabled by defining CPU_CTRL_PERF_EN.
module cpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_src_imm,
    output logic       rf_we,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic       instr_done,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_o
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t          state, state_next;
    logic [TO_W-1:0] to_cnt;
    logic            legal, uses_imm, to_hit;

    assign legal    = (opcode == OP_R) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_J);
    assign uses_imm = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
    // The wait that would push the count to MEM_TIMEOUT faults instead; an ack that cycle still wins.
    assign to_hit   = !mem_ack && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    assign state_o  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                to_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !mem_ack)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        reg_dst     = 1'b0;
        wb_sel      = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (to_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) state_next = S_HALT;
                else if (!legal)       state_next = S_FAULT;
                else                   state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_src_imm = uses_imm;
                if (opcode == OP_BEQ) begin
                    pc_we      = alu_zero;
                    pc_sel     = 2'b01;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (opcode == OP_J) begin
                    pc_we      = 1'b1;
                    pc_sel     = 2'b10;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req     = 1'b1;
                mem_we      = (opcode == OP_SW);
                alu_src_imm = 1'b1;
                if (mem_ack) begin
                    if (opcode == OP_SW) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (to_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                rf_we       = 1'b1;
                reg_dst     = (opcode == OP_R);
                wb_sel      = (opcode == OP_LW);
                alu_src_imm = (opcode == OP_ADDI);
                instr_done  = 1'b1;
                state_next  = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef CPU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALT && state != S_FAULT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks each instruction class, timeout, halt/fault and reset.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, start, alu_zero, mem_ack;
    logic [5:0] opcode;
    logic       mem_req, mem_we, ir_we, pc_we, alu_src_imm, rf_we, reg_dst, wb_sel;
    logic       instr_done, halted, fault;
    logic [1:0] pc_sel;
    logic [2:0] state_o;
`ifdef CPU_CTRL_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Output vector bit masks: {mem_req,mem_we,ir_we,pc_we,pc_sel,imm,rf_we,reg_dst,wb_sel,done,halted,fault}
    localparam logic [12:0] REQ = 13'h1000, WE = 13'h0800, IR = 13'h0400, PCW = 13'h0200;
    localparam logic [12:0] SJ = 13'h0100, SB = 13'h0080, IMM = 13'h0040, RF = 13'h0020;
    localparam logic [12:0] DST = 13'h0010, WBS = 13'h0008, DONE = 13'h0004, HLT = 13'h0002, FLT = 13'h0001;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111, OP_BAD = 6'b010101;

    logic [12:0] outs;
    assign outs = {mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src_imm, rf_we, reg_dst,
                   wb_sel, instr_done, halted, fault};

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .rf_we(rf_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .instr_done(instr_done), .halted(halted),
        .fault(fault), .state_o(state_o)
`ifdef CPU_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a falling edge; check state and outputs, then advance one cycle.
    task automatic step(input string tag, input logic [2:0] st, input logic [12:0] ov);
        #1;
        chk({tag, "_state"}, {29'd0, state_o}, {29'd0, st});
        chk({tag, "_outs"}, {19'd0, outs}, {19'd0, ov});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = OP_R; alu_zero = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset", 3'd0, 13'd0);

        // R-type, zero-wait memory: 0,1,2,3,5 then FETCH
        rst = 1'b0; start = 1'b1; mem_ack = 1'b1;
        step("r_idle", 3'd0, 13'd0);
        start = 1'b0;
        step("r_fetch", 3'd1, REQ | IR | PCW);
        step("r_dec", 3'd2, 13'd0);
        step("r_exec", 3'd3, 13'd0);
        step("r_wb", 3'd5, RF | DST | DONE);

        // LW with three wait cycles in MEM
        opcode = OP_LW;
        step("lw_fetch", 3'd1, REQ | IR | PCW);
        step("lw_dec", 3'd2, 13'd0);
        step("lw_exec", 3'd3, IMM);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", 3'd4, REQ | IMM);
        mem_ack = 1'b1;
        step("lw_mem_ack", 3'd4, REQ | IMM);
        step("lw_wb", 3'd5, RF | WBS | DONE);

        // BEQ taken then not taken
        opcode = OP_BEQ;
        step("beq1_fetch", 3'd1, REQ | IR | PCW);
        step("beq1_dec", 3'd2, 13'd0);
        alu_zero = 1'b1;
        step("beq1_exec", 3'd3, PCW | SB | DONE);
        alu_zero = 1'b0;
        step("beq2_fetch", 3'd1, REQ | IR | PCW);
        step("beq2_dec", 3'd2, 13'd0);
        step("beq2_exec", 3'd3, SB | DONE);

        // J, ADDI, zero-wait SW
        opcode = OP_J;
        step("j_fetch", 3'd1, REQ | IR | PCW);
        step("j_dec", 3'd2, 13'd0);
        step("j_exec", 3'd3, PCW | SJ | DONE);
        opcode = OP_ADDI;
        step("addi_fetch", 3'd1, REQ | IR | PCW);
        step("addi_dec", 3'd2, 13'd0);
        step("addi_exec", 3'd3, IMM);
        step("addi_wb", 3'd5, RF | IMM | DONE);
        opcode = OP_SW;
        step("sw_fetch", 3'd1, REQ | IR | PCW);
        step("sw_dec", 3'd2, 13'd0);
        step("sw_exec", 3'd3, IMM);
        step("sw_mem", 3'd4, REQ | WE | IMM | DONE);

        // Fetch timeout: 15 waiting cycles, then FAULT that persists until reset
        mem_ack = 1'b0;
        for (int i = 0; i < 15; i++) step("to_fetch", 3'd1, REQ);
        step("to_fault", 3'd7, FLT);
        mem_ack = 1'b1;
        step("to_fault_hold", 3'd7, FLT);
        rst = 1'b1;
        step("to_fault_rst", 3'd7, FLT);
        rst = 1'b0; mem_ack = 1'b0;
        step("to_rst_idle", 3'd0, 13'd0);

        // Ack on the limit cycle wins, then HALT ignores start
        start = 1'b1;
        step("lim_idle", 3'd0, 13'd0);
        start = 1'b0;
        for (int i = 0; i < 14; i++) step("lim_wait", 3'd1, REQ);
        mem_ack = 1'b1;
        step("lim_ack", 3'd1, REQ | IR | PCW);
        opcode = OP_HALT;
        step("halt_dec", 3'd2, 13'd0);
        step("halt0", 3'd6, HLT);
        start = 1'b1;
        step("halt_start", 3'd6, HLT);
        start = 1'b0;
        step("halt_hold", 3'd6, HLT);
        rst = 1'b1;
        step("halt_rst", 3'd6, HLT);

        // Illegal opcode faults from DECODE
        rst = 1'b0; start = 1'b1;
        step("bad_idle", 3'd0, 13'd0);
        start = 1'b0; opcode = OP_BAD;
        step("bad_fetch", 3'd1, REQ | IR | PCW);
        step("bad_dec", 3'd2, 13'd0);
        step("bad_fault", 3'd7, FLT);
        step("bad_hold", 3'd7, FLT);

        // Reset in the middle of a SW memory wait
        rst = 1'b1;
        step("sw2_pre_rst", 3'd7, FLT);
        rst = 1'b0; start = 1'b1; opcode = OP_SW;
        step("sw2_idle", 3'd0, 13'd0);
        start = 1'b0;
        step("sw2_fetch", 3'd1, REQ | IR | PCW);
        step("sw2_dec", 3'd2, 13'd0);
        step("sw2_exec", 3'd3, IMM);
        mem_ack = 1'b0;
        step("sw2_mem", 3'd4, REQ | WE | IMM);
        rst = 1'b1;
        step("sw2_mem_rst", 3'd4, REQ | WE | IMM);
        rst = 1'b0;
        step("sw2_after_rst", 3'd0, 13'd0);

`ifdef CPU_CTRL_PERF_EN
        start = 1'b1; opcode = OP_R; mem_ack = 1'b1;
        step("perf_idle", 3'd0, 13'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("perf_fetch", 3'd1, REQ | IR | PCW);
            step("perf_dec", 3'd2, 13'd0);
            step("perf_exec", 3'd3, 13'd0);
            step("perf_wb", 3'd5, RF | DST | DONE);
        end
        chk("perf_retired", retired_cnt, 32'd3);
        chk("perf_cycles", cycle_cnt, 32'd12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the bubble-machine CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC, IR, register-file, ALU-source and memory-request enables.
- Sits between the instruction/data memory handshake and the CPU datapath, replacing single-cycle hardwired control.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for mem_ack in FETCH or MEM before entering FAULT (1..255).
- TO_W, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- opcode  input  6  IR[31:26] from datapath.
- alu_zero  input  1  ALU zero flag, valid in EXEC.
- mem_ack  input  1  memory completes current request this cycle.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write (SW), 0 = read.
- ir_we  output  1  load IR.
- pc_we  output  1  update PC.
- pc_sel  output  2  00 = PC+1, 01 = branch target, 10 = jump target.
- alu_src_imm  output  1  ALU operand B = sign-extended immediate.
- rf_we  output  1  register-file write.
- reg_dst  output  1  1 = rd, 0 = rt.
- wb_sel  output  1  1 = memory data, 0 = ALU result.
- instr_done  output  1  one-cycle pulse per retired instruction.
- halted  output  1  HALT reached.
- fault  output  1  illegal opcode or memory timeout.
- state_o  output  3  current state, for debug.

Behaviour:
- Reset:
  - rst is synchronous and active-high; it overrides everything, including mid-instruction.
  - On reset: state = IDLE (0), timeout counter = 0, every output = 0.
- State register: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Outputs: combinational from the state register plus mem_ack/alu_zero where stated; every output not listed for a state is 0.
- Opcodes: R=000000, ADDI=001000, LW=100011, SW=101011, BEQ=000100, J=000010, HALT=111111. Any other opcode is illegal.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_req=1, mem_we=0.
  - If mem_ack: ir_we=1, pc_we=1, pc_sel=00 in that same cycle, then -> DECODE.
- DECODE: one cycle, no enables.
  - HALT -> HALT.
  - Illegal opcode -> FAULT.
  - Otherwise -> EXEC.
- EXEC:
  - alu_src_imm=1 for ADDI/LW/SW.
  - BEQ: pc_we=alu_zero, pc_sel=01, instr_done=1 -> FETCH.
  - J: pc_we=1, pc_sel=10, instr_done=1 -> FETCH.
  - LW/SW -> MEM.
  - R/ADDI -> WB.
- MEM:
  - mem_req=1, mem_we=1 for SW, alu_src_imm=1.
  - On mem_ack: SW gives instr_done=1 -> FETCH; LW -> WB.
- WB:
  - rf_we=1, reg_dst=1 only for R, wb_sel=1 only for LW, alu_src_imm=1 for ADDI.
  - instr_done=1 -> FETCH.
- HALT: halted=1; stays until reset; start is ignored.
- FAULT: fault=1; stays until reset.
- Opcode stability: the datapath holds IR stable from DECODE until the next FETCH, so the FSM reads opcode directly in DECODE/EXEC/MEM/WB.
- Memory timeout:
  - Counter clears on every entry to FETCH or MEM and increments each cycle in those states while mem_ack=0.
  - When count reaches MEM_TIMEOUT with mem_ack still 0 -> FAULT.
  - mem_ack in the same cycle as the limit wins (normal transition).
- mem_ack outside FETCH/MEM is ignored.
- CPI: R/ADDI=4, BEQ/J=3, SW=4, LW=5 cycles with zero-wait memory. Each wait cycle adds 1.

Optional Feature:
- Macro: CPU_CTRL_PERF_EN.
- Defined:
  - Adds outputs cycle_cnt (32) and retired_cnt (32), both cleared by rst.
  - cycle_cnt increments every cycle the state is not IDLE/HALT/FAULT.
  - retired_cnt increments on each instr_done.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with zero-wait memory, opcode=000000 -> states 0,1,2,3,5,1; rf_we=1 and reg_dst=1 in WB; instr_done pulses exactly once.
2. LW (100011) with mem_ack delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with wb_sel=1, rf_we=1; 8 cycles total from FETCH.
3. BEQ with alu_zero=1 -> EXEC asserts pc_we=1, pc_sel=01, then FETCH. Repeat with alu_zero=0 -> pc_we=0, pc_sel=01, then FETCH.
4. mem_ack held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT after 15 cycles, fault=1 persists; rst=1 -> IDLE, all outputs 0.
5. Opcode 111111 -> HALT, halted=1. Opcode 010101 -> FAULT from DECODE. start pulses in HALT have no effect.
6. rst asserted mid-MEM of a SW -> next cycle IDLE, mem_req=0. With CPU_CTRL_PERF_EN: run 3 R instructions -> retired_cnt=3, cycle_cnt=12.
